pe_array_matcher: RTL
=====================

PE_ARRAY_MATCHER -- requirements
Module: pe_array_matcher

Interface
REQ-001 SHALL have parameter NUM_PE, default 16, number of pattern elements (PEs), range 2..64.
REQ-002 SHALL have parameter CHAR_W, default 8, width of one text/pattern character.
REQ-003 SHALL have parameter POS_W, default 16, width of the text position counter.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port pat_clear  input  1  discard the loaded pattern and return to IDLE.
REQ-007 SHALL have port key_valid  input  1  pattern-element word offered.
REQ-008 SHALL have port key_ready  output  1  pattern-element word accepted when key_valid is also high.
REQ-009 SHALL have port key_data  input  CHAR_W+1  {wildcard flag, character}.
REQ-010 SHALL have port key_last  input  1  this element ends the pattern.
REQ-011 SHALL have port text_valid  input  1  text character offered.
REQ-012 SHALL have port text_ready  output  1  text character accepted when text_valid is also high.
REQ-013 SHALL have port text_data  input  CHAR_W  text character.
REQ-014 SHALL have port text_last  input  1  final character of the text stream.
REQ-015 SHALL have port match_valid  output  1  a match report is pending.
REQ-016 SHALL have port match_ready  input  1  consumer accepts the pending match report.
REQ-017 SHALL have port match_pos  output  POS_W  stream index of the character that completed the match.
REQ-018 SHALL have port pat_len  output  $clog2(NUM_PE+1)  number of loaded elements.
REQ-019 SHALL have port busy  output  1  high in the RUN state.

Function
REQ-020 SHALL implement a three-state FSM: IDLE, LOAD and RUN.
REQ-021 SHALL move IDLE->LOAD on the first accepted key; SHALL move LOAD->RUN on an accepted key with key_last=1, or on the NUM_PE-th accepted key, whichever occurs first.
REQ-022 SHALL drive key_ready=1 only in IDLE/LOAD and only while pat_clear=0; SHALL write accepted key k into PE k and increment pat_len.
REQ-023 SHALL drive text_ready = busy & !pat_clear & (!match_valid | match_ready).
REQ-024 SHALL update the PE state vector s[0..NUM_PE-1] only on an accepted text character, where hit_i = (char_i == text_data), or 1 for a wildcard element (see REQ-034).
REQ-025 SHALL compute the PE state update as: s0' = hit_0; si' = s(i-1) & hit_i for i < pat_len; si' = 0 for i >= pat_len.
REQ-026 SHALL report a match when s(pat_len-1)' = 1.
REQ-027 SHALL report every match, including overlapping matches; for example, pattern "aa" on text "aaa" reports positions 1 and 2.
REQ-028 SHALL assert match_valid on the cycle after the completing character is accepted, with match_pos equal to that character's index (first character is index 0).
REQ-029 SHALL hold match_valid and match_pos stable until match_ready=1; SHALL accept back-to-back text with match_ready held high, giving one report per cycle.
REQ-030 SHALL advance the position counter by 1 per accepted character and wrap it modulo 2^POS_W.
REQ-031 SHALL, when text_last is accepted, still report any match on that character, then clear s and the position counter to 0 and stay in RUN.
REQ-032 SHALL, on pat_clear (any state), go to IDLE on the next edge and clear s, pat_len, the position counter and match_valid; pat_clear SHALL take priority over any simultaneous key, text or match handshake.

Reset
REQ-033 SHALL, on reset=1 at a clock edge, set state=IDLE, s=0, pat_len=0, position=0 and match_valid=0, so that after reset key_ready=1, text_ready=0, busy=0 and match_pos=0; reset SHALL override all other inputs, including mid-load and mid-stream.

Configuration
REQ-034 SHALL, when macro PE_WILDCARD_EN is defined, make an element with wildcard flag=1 match any character; when the macro is undefined, SHALL ignore the flag and store no wildcard bit, so the element compares literally.

Verification
REQ-035 SHALL cover: load "abc" (key_last on 'c'), stream "xabcabc" -> match_pos 3 then 6, pat_len=3.
REQ-036 SHALL cover: pattern "aa", stream "aaaa" with match_ready=1 -> reports at 1, 2, 3 on consecutive cycles.
REQ-037 SHALL cover: with PE_WILDCARD_EN, pattern 'a',*,'c' and text "abcazc" -> matches at 2 and 5; without the macro and the same key words -> no match.
REQ-038 SHALL cover: match_ready=0 for 5 cycles with a pending match -> text_ready=0 and match_pos held for those 5 cycles; no characters lost.
REQ-039 SHALL cover: load NUM_PE keys with no key_last -> RUN entered and key_ready=0; then assert pat_clear during streaming -> IDLE next cycle, match_valid=0, pat_len=0.
REQ-040 SHALL cover: text "ab" with text_last on 'b', then "b" -> pattern "ab" does not match across the stream boundary, and the new stream starts at position 0.

Source files
------------

// File: rtl/pe_array_matcher.sv
// pe_array_matcher: systolic-style exact/wildcard pattern matcher.
// A pattern of up to NUM_PE elements is loaded through the key stream.
// Text is then streamed one character per accepted beat, and every
// (possibly overlapping) match is reported with the index of its last
// character.
// Optional feature: define PE_WILDCARD_EN to honour the wildcard flag in
// key_data[CHAR_W]. Without it the flag is dropped and elements compare literally.

// One pattern element: stores its character and reports whether it accepts
// the current text character.
module pe_cell #(
   parameter int CHAR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we_i,
   input  logic [CHAR_W:0]   key_i,
   input  logic [CHAR_W-1:0] text_i,
   output logic              hit_o
);
   logic [CHAR_W-1:0] chr_q;

   // capture the element character when this PE is the load target
   always_ff @(posedge clk) begin
      if (reset)     chr_q <= '0;
      else if (we_i) chr_q <= key_i[CHAR_W-1:0];
   end

`ifdef PE_WILDCARD_EN
   logic wc_q;

   // capture the wildcard flag alongside the character
   always_ff @(posedge clk) begin
      if (reset)     wc_q <= 1'b0;
      else if (we_i) wc_q <= key_i[CHAR_W];
   end

   assign hit_o = wc_q | (chr_q == text_i);
`else
   logic unused_wc;
   assign unused_wc = key_i[CHAR_W];
   assign hit_o     = (chr_q == text_i);
`endif
endmodule

module pe_array_matcher #(
   parameter int NUM_PE = 16,
   parameter int CHAR_W = 8,
   parameter int POS_W  = 16,
   localparam int PLEN_W = $clog2(NUM_PE + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pat_clear,
   input  logic              key_valid,
   output logic              key_ready,
   input  logic [CHAR_W:0]   key_data,
   input  logic              key_last,
   input  logic              text_valid,
   output logic              text_ready,
   input  logic [CHAR_W-1:0] text_data,
   input  logic              text_last,
   output logic              match_valid,
   input  logic              match_ready,
   output logic [POS_W-1:0]  match_pos,
   output logic [PLEN_W-1:0] pat_len,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t              state_q, state_d;
   logic [PLEN_W-1:0]   plen_q, plen_d;
   logic [NUM_PE-1:0]   s_q, s_d, s_nxt, hit, pe_we;
   logic [POS_W-1:0]    pos_q, pos_d, mpos_q, mpos_d;
   logic                mv_q, mv_d;
   logic                key_fire, text_fire, match_hit;

   assign key_fire   = key_valid & key_ready;
   assign text_ready = busy & ~pat_clear & (~mv_q | match_ready);
   assign text_fire  = text_valid & text_ready;

   // per-element storage and comparators
   for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
      assign pe_we[k] = key_fire & (plen_q == PLEN_W'(k));
      pe_cell #(.CHAR_W(CHAR_W)) u_pe (
         .clk    (clk),
         .reset  (reset),
         .we_i   (pe_we[k]),
         .key_i  (key_data),
         .text_i (text_data),
         .hit_o  (hit[k])
      );
   end

   // FSM next state and handshake outputs; pat_clear overrides everything
   always_comb begin
      state_d   = state_q;
      key_ready = 1'b0;
      busy      = (state_q == RUN);
      case (state_q)
         IDLE, LOAD: begin
            key_ready = ~pat_clear;
            if (key_fire)
               state_d = (key_last || plen_q == PLEN_W'(NUM_PE - 1)) ? RUN : LOAD;
         end
         default: ;
      endcase
      if (pat_clear) state_d = IDLE;
   end

   // shift-and-match: each PE extends the partial match of its predecessor
   always_comb begin
      s_nxt     = '0;
      match_hit = 1'b0;
      for (int i = 0; i < NUM_PE; i++) begin
         if (PLEN_W'(i) < plen_q)
            s_nxt[i] = hit[i] & ((i == 0) ? 1'b1 : s_q[(i == 0) ? 0 : i - 1]);
         if (PLEN_W'(i + 1) == plen_q)
            match_hit = s_nxt[i];
      end
   end

   // datapath next state: pattern length, PE state, position and match report
   always_comb begin
      plen_d = plen_q;
      s_d    = s_q;
      pos_d  = pos_q;
      mv_d   = mv_q;
      mpos_d = mpos_q;
      if (key_fire) plen_d = plen_q + 1'b1;
      if (mv_q && match_ready) mv_d = 1'b0;
      if (text_fire) begin
         if (match_hit) begin
            mv_d   = 1'b1;
            mpos_d = pos_q;
         end
         // end of stream: no partial match may carry into the next stream
         s_d   = text_last ? '0 : s_nxt;
         pos_d = text_last ? '0 : pos_q + 1'b1;
      end
      if (pat_clear) begin
         plen_d = '0;
         s_d    = '0;
         pos_d  = '0;
         mv_d   = 1'b0;
         mpos_d = '0;
      end
   end

   // state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         plen_q  <= '0;
         s_q     <= '0;
         pos_q   <= '0;
         mv_q    <= 1'b0;
         mpos_q  <= '0;
      end else begin
         state_q <= state_d;
         plen_q  <= plen_d;
         s_q     <= s_d;
         pos_q   <= pos_d;
         mv_q    <= mv_d;
         mpos_q  <= mpos_d;
      end
   end

   assign match_valid = mv_q;
   assign match_pos   = mpos_q;
   assign pat_len     = plen_q;
endmodule
